alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream/downstream wrapper stage for the 4-bit ALU (registered 5-bit output C).
//  Buffers incoming ALU commands in a FIFO and drives A/B/opcode to the ALU one per cycle.
//  Tracks each issued op through the ALU's one-cycle register latency.
//  Captures C into a result FIFO and presents it on a valid/ready port with the opcode echoed.
//  Credit-based issue guarantees no result is lost under backpressure; the ALU itself has no stall.
// PARAMETERS
//  CMD_DEPTH  4  command FIFO entries (power of 2, >=2)
//  RES_DEPTH  4  result FIFO entries (power of 2, >=3 for full 1/cycle throughput)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-low reset (0 = reset)
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command FIFO not full
//  cmd_opcode  in   2   0 ADD, 1 SUB, 2 NOT A, 3 OR-reduce B
//  cmd_a       in   4   operand A
//  cmd_b       in   4   operand B
//  alu_a       out  4   to ALU A (registered)
//  alu_b       out  4   to ALU B (registered)
//  alu_opcode  out  2   to ALU opcode (registered)
//  alu_c       in   5   from ALU registered output C
//  res_valid   out  1   result FIFO not empty
//  res_ready   in   1   consumer accepts result
//  res_data    out  5   result (2's complement, as produced by ALU)
//  res_opcode  out  2   opcode that produced res_data
//  busy        out  1   any command queued, in flight, or result pending
// BEHAVIOUR
//  Reset (reset==0 at clk edge): both FIFOs empty, alu_a/alu_b/alu_opcode=0, in-flight flags
//   cleared, cmd_ready=0 during reset, res_valid=0, res_data=0, res_opcode=0, busy=0.
//  Top level drives the ALU's active-high reset from !reset.
//  Accept: cmd_valid && cmd_ready at edge E0 writes {opcode,a,b} into command FIFO.
//  Issue at edge when cmd FIFO non-empty and credit ok: pop head, load alu_* regs, set iss1.
//   credit ok <=> res_count + iss1 + iss2 - (res_valid && res_ready) < RES_DEPTH.
//  Pipeline: iss1 -> iss2 next edge (carries opcode); while iss2==1, alu_c is the result
//   and is written to result FIFO at that edge with the carried opcode.
//  Latency: accept at E0 -> issue E1 -> ALU C at E2 -> res_valid high after E3 (3 cycles).
//  Throughput: 1 op/cycle sustained when res_ready==1 and RES_DEPTH>=3.
//  No issue: alu_* regs hold value; ALU keeps recomputing but alu_c is ignored (iss2==0).
//  Cmd FIFO full: cmd_ready=0; no push-through on a same-cycle pop (ready from registered count).
//  Result FIFO: push and pop same cycle allowed at any level incl. full; order strictly FIFO.
//  Credit guarantees result FIFO never overflows; overflow is an assertion failure.
//  Pointers wrap modulo depth; counts are log2(depth)+1 bits.
//  Reset mid-operation: all queued and in-flight ops discarded; no res_valid after release.
//  res_data/res_opcode stable while res_valid && !res_ready (assertion).
// STRUCTURE
//  alu_pkg: opcode enum (OP_ADD=2'd0, OP_SUB=2'd1, OP_NOT=2'd2, OP_ORR=2'd3),
//   localparams OPND_W=4, RES_W=5, cmd_t struct {opcode,a,b}, res_t struct {opcode,data}.
//  Sub-module sync_fifo #(WIDTH,DEPTH) (sync active-low reset, full/empty/count), instanced
//   twice: cmd_t FIFO and res_t FIFO. Issue/credit logic and iss1/iss2 pipe in top.
// TESTING (bench instantiates this block plus the ALU)
//  Reset: reset=0 for 2 cycles -> cmd_ready=0, res_valid=0, alu_a/b/opcode=0, busy=0.
//  ADD a=3 b=4, res_ready=1 -> res_data=5'd7, res_opcode=0, exactly 3 cycles after accept.
//  SUB 2-5 -> 5'b11101; NOT a=4'b0101 -> 5'b11010; ORR b=0 -> 0; ORR b=8 -> 1; in order.
//  Backpressure: res_ready=0, offer 10 cmds -> 4 results held, cmd_ready=0 after 8 accepted
//   (4 in res FIFO, 4 in cmd FIFO); raise res_ready -> all 10 results, in order, none lost.
//  Back-to-back: 16 random cmds, res_ready=1 -> one res_valid per cycle, matches model.
//  Reset mid-op: 2 in flight + 2 queued, pulse reset=0 one cycle -> no res_valid afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, operand widths,
// and the command/result bundles carried through the FIFOs.
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_NOT = 2'd2,
        OP_ORR = 2'd3
    } opcode_e;

    typedef struct packed {
        opcode_e             opcode;
        logic [OPND_W-1:0]   a;
        logic [OPND_W-1:0]   b;
    } cmd_t;

    typedef struct packed {
        opcode_e             opcode;
        logic [RES_W-1:0]    data;
    } res_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with active-low sync reset; push and pop may coincide
// at any fill level, including full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, issues one per cycle under result-FIFO credit,
// tracks the ALU's register latency and returns results with their opcode.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_opcode,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [1:0]        alu_opcode,
    input  logic [RES_W-1:0]  alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [1:0]        res_opcode,
    output logic              busy
);

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RES_DEPTH) + 1;

    logic [$bits(cmd_t)-1:0] cmd_wvec, cmd_rvec;
    logic [$bits(res_t)-1:0] res_wvec, res_rvec;
    cmd_t            cmd_head;
    res_t            res_head;
    logic            cmd_full, cmd_empty, cmd_push;
    logic            res_full, res_empty, res_push, res_pop;
    logic [CCW-1:0]  cmd_count;
    logic [RCW-1:0]  res_count;
    logic [RCW:0]    occ, lim;
    logic            credit_ok, issue;

    logic [OPND_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    opcode_e           alu_op_q, alu_op_d, op2_q, op2_d;
    logic              iss1_q, iss1_d, iss2_q, iss2_d;

    assign cmd_ready = reset && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_wvec  = {cmd_opcode, cmd_a, cmd_b};
    assign cmd_head  = cmd_t'(cmd_rvec);

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (cmd_push),
        .wdata_i (cmd_wvec),
        .pop_i   (issue),
        .rdata_o (cmd_rvec),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    // Every op already issued owns a result slot, so the ALU never needs a stall.
    assign occ       = (RCW+1)'(res_count) + (RCW+1)'(iss1_q) + (RCW+1)'(iss2_q);
    assign lim       = (RCW+1)'(RES_DEPTH) + (RCW+1)'(res_pop);
    assign credit_ok = occ < lim;
    assign issue     = !cmd_empty && credit_ok;

    always_comb begin
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        iss1_d   = issue;
        iss2_d   = iss1_q;
        op2_d    = alu_op_q;
        if (issue) begin
            alu_a_d  = cmd_head.a;
            alu_b_d  = cmd_head.b;
            alu_op_d = cmd_head.opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_ADD;
            op2_q    <= OP_ADD;
            iss1_q   <= 1'b0;
            iss2_q   <= 1'b0;
        end else begin
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            op2_q    <= op2_d;
            iss1_q   <= iss1_d;
            iss2_q   <= iss2_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;

    assign res_push = iss2_q;
    assign res_wvec = {op2_q, alu_c};
    assign res_pop  = res_valid && res_ready;
    assign res_head = res_t'(res_rvec);

    sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (res_push),
        .wdata_i (res_wvec),
        .pop_i   (res_pop),
        .rdata_o (res_rvec),
        .full_o  (res_full),
        .empty_o (res_empty),
        .count_o (res_count)
    );

    assign res_valid  = !res_empty;
    assign res_data   = res_head.data;
    assign res_opcode = res_head.opcode;
    assign busy       = (cmd_count != '0) || iss1_q || iss2_q || !res_empty;

    a_res_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(res_push && res_full && !res_pop));

    a_res_stable: assert property (@(posedge clk) disable iff (!reset)
        (res_valid && !res_ready) |=> ($stable(res_data) && $stable(res_opcode)));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU and a queue scoreboard.
module tb_alu_op_sequencer;

    typedef struct {
        logic [1:0] op;
        logic [4:0] data;
        int         e0;
        bit         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_opcode;
    logic [3:0] cmd_a, cmd_b;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_opcode;
    logic [4:0] alu_c;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [1:0] res_opcode;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    int   pop_cyc[$];

    alu_op_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_opcode (res_opcode),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU with registered output; its active-high reset is !reset.
    always_ff @(posedge clk) begin
        if (!reset) alu_c <= '0;
        else begin
            case (alu_opcode)
                2'd0: alu_c <= {1'b0, alu_a} + {1'b0, alu_b};
                2'd1: alu_c <= {1'b0, alu_a} - {1'b0, alu_b};
                2'd2: alu_c <= ~{1'b0, alu_a};
                default: alu_c <= {4'b0, |alu_b};
            endcase
        end
    end

    function automatic logic [4:0] model(int op, int a, int b);
        case (op)
            0: return 5'((a + b) % 32);
            1: return 5'((a - b + 32) % 32);
            2: return 5'(31 - a);
            default: return (b != 0) ? 5'd1 : 5'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard monitor: any result shown must be expected; popped ones are compared.
    always @(negedge clk) begin
        if (reset === 1'b1 && res_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res got data %0d op %0d expected none",
                         res_data, res_opcode);
            end else if (res_ready === 1'b1) begin
                exp_t e;
                e = sbq.pop_front();
                pop_cyc.push_back(cyc);
                chk("res_data", int'(res_data), int'(e.data));
                chk("res_opcode", int'(res_opcode), int'(e.op));
                if (e.lat) chk("latency", cyc - e.e0, 3);
            end
        end
    end

    task automatic send(input int op, input int a, input int b, input bit lat,
                        input int tmo, output bit ok);
        exp_t e;
        cmd_valid  = 1'b1;
        cmd_opcode = 2'(op);
        cmd_a      = 4'(a);
        cmd_b      = 4'(b);
        ok = 1'b0;
        for (int i = 0; i < tmo; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                e.op   = 2'(op);
                e.data = model(op, a, b);
                e.e0   = cyc + 1;
                e.lat  = lat;
                sbq.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic send_chk(input int op, input int a, input int b, input bit lat);
        bit ok;
        send(op, a, b, lat, 20, ok);
        chk("accept", int'(ok), 1);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && busy === 1'b0) break;
        end
        chk(name, int'(sbq.size() == 0 && busy === 1'b0), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int base;
        int hop, ha, hb;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        res_ready  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_op", int'(alu_opcode), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_data", int'(res_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        res_ready = 1'b1;
        send_chk(0, 3, 4, 1'b1);
        idle();
        drain("drain_add");

        send_chk(1, 2, 5, 1'b0);
        send_chk(2, 5, 0, 1'b0);
        send_chk(3, 9, 0, 1'b0);
        send_chk(3, 2, 8, 1'b0);
        idle();
        drain("drain_directed");

        // Backpressure: 4 results held plus 4 queued commands, then stall.
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send_chk(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), 1'b0);
        hop = int'($urandom_range(0, 3));
        ha  = int'($urandom_range(0, 15));
        hb  = int'($urandom_range(0, 15));
        send(hop, ha, hb, 1'b0, 20, ok);
        chk("bp_ninth_blocked", int'(ok), 0);
        @(negedge clk);
        chk("bp_cmd_ready", int'(cmd_ready), 0);
        chk("bp_res_valid", int'(res_valid), 1);
        chk("bp_busy", int'(busy), 1);
        chk("bp_held", sbq.size(), 8);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send_chk(hop, ha, hb, 1'b0);
        send_chk(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'b0);
        idle();
        drain("drain_bp");

        base = pop_cyc.size();
        for (int i = 0; i < 16; i++)
            send_chk(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), 1'b0);
        idle();
        drain("drain_b2b");
        if (pop_cyc.size() >= base + 16)
            chk("b2b_span", pop_cyc[base+15] - pop_cyc[base], 15);
        else
            chk("b2b_count", pop_cyc.size() - base, 16);

        // Reset mid-operation discards everything queued and in flight.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_chk(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), 1'b0);
        idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_res_valid", int'(res_valid), 0);
        end
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
